// File: rtl/spi_ram_scan_ctrl_if.sv
// Host and SPI pin bundle for the sensor RAM scan controller.
// Pure wiring: no storage, so it adds no latency.
// No backpressure: start is a one-cycle request gated by busy.
interface spi_ram_scan_ctrl_if;
    // system-controller side
    logic        start;
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [10:0] wdata;
    logic        busy;
    logic        done;
    logic        res_valid;
    logic [3:0]  res_addr;
    logic [10:0] res_data;
`ifdef SPI_WRITE_VERIFY_EN
    logic        verify_err;
`endif
    // SPI pins towards the sensor RAM slave
    logic        spi_clk;
    logic        csb;
    logic        ldb;
    logic        mosi;
    logic        miso;

    // controller view
    modport master (
        input  start, op, addr, wdata, miso,
        output busy, done, res_valid, res_addr, res_data,
        output spi_clk, csb, ldb, mosi
`ifdef SPI_WRITE_VERIFY_EN
        , output verify_err
`endif
    );

    // environment view (system controller plus RAM slave)
    modport slave (
        output start, op, addr, wdata, miso,
        input  busy, done, res_valid, res_addr, res_data,
        input  spi_clk, csb, ldb, mosi
`ifdef SPI_WRITE_VERIFY_EN
        , input verify_err
`endif
    );
endinterface

// File: rtl/spi_ram_scan_ctrl.sv
// SPI master/sequencer for a 16x11 sensor RAM: LDB snapshot + 16-frame scan, single read, single write.
// Latency: busy the clk after an accepted start; each frame is 1 setup half + 32 halves + GAP_CYC clks.
// No backpressure: start is ignored unless idle; results are one-cycle strobes with no stall.
// Optional build macro SPI_WRITE_VERIFY_EN adds a read-back frame after single writes and verify_err.
module spi_ram_scan_ctrl #(
    parameter int CLK_DIV  = 4,  // clk cycles per spi_clk half-period, 2..255
    parameter int GAP_CYC  = 4,  // clk cycles csb stays high between frames
    parameter int LDB_CLKS = 2   // spi_clk pulses with ldb low during the snapshot
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_ram_scan_ctrl_if.master  bus
);
    localparam logic [7:0] HP_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);
    localparam logic [7:0] LOAD_LAST = 8'(2 * LDB_CLKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hp_q, hp_d;        // clk count within the current half-period
    logic [7:0]  half_q, half_d;    // half-period index inside the LOAD phase
    logic [3:0]  bit_q, bit_d;      // frame bit index 0..15
    logic [7:0]  gap_q, gap_d;
    logic [3:0]  chan_q, chan_d;    // scan channel
    logic [1:0]  op_q, op_d;
    logic [3:0]  addr_q, addr_d;
    logic [10:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;        // current frame is a read
    logic        first_q, first_d;  // first frame after the snapshot: no channel increment
    logic [10:0] shift_q, shift_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        res_valid_q, res_valid_d;
    logic [3:0]  res_addr_q, res_addr_d;
    logic [10:0] res_data_q, res_data_d;
    logic        spi_clk_q, spi_clk_d;
    logic        csb_q, csb_d;
    logic        ldb_q, ldb_d;
    logic        mosi_q, mosi_d;
`ifdef SPI_WRITE_VERIFY_EN
    logic        vfy_q, vfy_d;      // read-back frame of a verified write is in progress
    logic        verify_err_q, verify_err_d;
`endif

    logic        tick;
    logic        is_scan;
    logic [3:0]  faddr;
    logic [15:0] frame;

    assign tick    = (hp_q == HP_LAST);
    assign is_scan = (op_q == 2'b00) || (op_q == 2'b11);
    assign faddr   = is_scan ? chan_q : addr_q;
    // bit0 of the frame is frame[15]
    assign frame   = {rd_q, faddr, (rd_q ? 11'd0 : wdata_q)};

    // State and output registers; reset puts every pin at its idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hp_q         <= '0;
            half_q       <= '0;
            bit_q        <= '0;
            gap_q        <= '0;
            chan_q       <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            first_q      <= 1'b0;
            shift_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_addr_q   <= '0;
            res_data_q   <= '0;
            spi_clk_q    <= 1'b0;
            csb_q        <= 1'b1;
            ldb_q        <= 1'b1;
            mosi_q       <= 1'b0;
`ifdef SPI_WRITE_VERIFY_EN
            vfy_q        <= 1'b0;
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hp_q         <= hp_d;
            half_q       <= half_d;
            bit_q        <= bit_d;
            gap_q        <= gap_d;
            chan_q       <= chan_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            first_q      <= first_d;
            shift_q      <= shift_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            res_valid_q  <= res_valid_d;
            res_addr_q   <= res_addr_d;
            res_data_q   <= res_data_d;
            spi_clk_q    <= spi_clk_d;
            csb_q        <= csb_d;
            ldb_q        <= ldb_d;
            mosi_q       <= mosi_d;
`ifdef SPI_WRITE_VERIFY_EN
            vfy_q        <= vfy_d;
            verify_err_q <= verify_err_d;
`endif
        end
    end

    // Sequencer: next state, half-period timing, serial shifting and result strobes.
    always_comb begin
        state_d      = state_q;
        hp_d         = '0;
        half_d       = half_q;
        bit_d        = bit_q;
        gap_d        = gap_q;
        chan_d       = chan_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        first_d      = first_q;
        shift_d      = shift_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        res_valid_d  = 1'b0;
        res_addr_d   = res_addr_q;
        res_data_d   = res_data_q;
        spi_clk_d    = spi_clk_q;
        csb_d        = csb_q;
        ldb_d        = ldb_q;
        mosi_d       = mosi_q;
`ifdef SPI_WRITE_VERIFY_EN
        vfy_d        = vfy_q;
        verify_err_d = verify_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    busy_d  = 1'b1;
                    chan_d  = '0;
                    half_d  = '0;
                    rd_d    = (bus.op != 2'b10);
                    csb_d   = 1'b0;
`ifdef SPI_WRITE_VERIFY_EN
                    vfy_d        = 1'b0;
                    verify_err_d = 1'b0;
`endif
                    if (bus.op == 2'b01 || bus.op == 2'b10) begin
                        first_d = 1'b0;
                        state_d = S_SETUP;
                    end else begin
                        first_d = 1'b1;
                        ldb_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end

            // half 0 is the low lead-in, then odd halves high, even halves low
            S_LOAD: begin
                hp_d = tick ? 8'd0 : hp_q + 8'd1;
                if (tick) begin
                    if (half_q == LOAD_LAST) begin
                        spi_clk_d = 1'b0;
                        ldb_d     = 1'b1;
                        csb_d     = 1'b1;
                        gap_d     = '0;
                        state_d   = S_GAP;
                    end else begin
                        half_d    = half_q + 8'd1;
                        spi_clk_d = ~half_q[0];
                    end
                end
            end

            S_SETUP: begin
                hp_d = tick ? 8'd0 : hp_q + 8'd1;
                if (tick) begin
                    spi_clk_d = 1'b1;
                    mosi_d    = frame[15];
                    bit_d     = '0;
                    state_d   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                hp_d = tick ? 8'd0 : hp_q + 8'd1;
                if (tick) begin
                    if (spi_clk_q) begin
                        // falling edge: capture data bits of read frames
                        spi_clk_d = 1'b0;
                        if (rd_q && (bit_q >= 4'd5)) begin
                            shift_d = {shift_q[9:0], bus.miso};
                        end
                        if (bit_q == 4'd15) begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        // rising edge: advance and present the next bit
                        spi_clk_d = 1'b1;
                        bit_d     = bit_q + 4'd1;
                        mosi_d    = frame[4'd14 - bit_q];
                    end
                end
            end

            S_HOLD: begin
                hp_d = tick ? 8'd0 : hp_q + 8'd1;
                if (tick) begin
                    csb_d   = 1'b1;
                    mosi_d  = 1'b0;
                    gap_d   = '0;
                    state_d = S_GAP;
                    if (rd_q) begin
                        res_valid_d = 1'b1;
                        res_addr_d  = faddr;
                        res_data_d  = shift_q;
                    end
`ifdef SPI_WRITE_VERIFY_EN
                    if (vfy_q) begin
                        verify_err_d = (shift_q != wdata_q);
                    end
`endif
                end
            end

            S_GAP: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (is_scan && first_q) begin
                        first_d = 1'b0;
                        csb_d   = 1'b0;
                        state_d = S_SETUP;
                    end else if (is_scan && (chan_q != 4'd15)) begin
                        chan_d  = chan_q + 4'd1;
                        csb_d   = 1'b0;
                        state_d = S_SETUP;
`ifdef SPI_WRITE_VERIFY_EN
                    end else if ((op_q == 2'b10) && !vfy_q) begin
                        vfy_d   = 1'b1;
                        rd_d    = 1'b1;
                        csb_d   = 1'b0;
                        state_d = S_SETUP;
`endif
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end

            // done is high this cycle; a start seen here is dropped
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_addr  = res_addr_q;
    assign bus.res_data  = res_data_q;
    assign bus.spi_clk   = spi_clk_q;
    assign bus.csb       = csb_q;
    assign bus.ldb       = ldb_q;
    assign bus.mosi      = mosi_q;
`ifdef SPI_WRITE_VERIFY_EN
    assign bus.verify_err = verify_err_q;
`endif
endmodule

// File: doc/spi_ram_scan_ctrl.md
Name: spi_ram_scan_ctrl

Overview:
- SPI master and sequencer for the 16-entry x 11-bit sensor RAM slave: single clock domain, generates spi_clk, csb, ldb and mosi, and samples miso.
- On request, runs one of three operations:
  - Full scan: LDB snapshot, then 16 read frames.
  - Single read.
  - Single write.
- Read results go out on a per-channel result strobe. Sits between the system controller and the sensor RAM slave.

Parameters:
- CLK_DIV, 4, clk cycles per spi_clk half-period (legal range 2..255).
- GAP_CYC, 4, clk cycles csb is held high between frames.
- LDB_CLKS, 2, spi_clk pulses issued with ldb low during the snapshot phase.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- op  in  2  operation: 00 scan, 01 single read, 10 single write, 11 reserved (treated as scan).
- addr  in  4  RAM address for single read/write; sampled at start.
- wdata  in  11  write data; sampled at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at end of operation.
- res_valid  out  1  one-cycle strobe per completed read frame.
- res_addr  out  4  address of the result.
- res_data  out  11  read data, MSB first as received.
- spi_clk  out  1  SPI clock; idles low.
- csb  out  1  chip select, active low; idles high.
- ldb  out  1  load strobe, active low; idles high.
- mosi  out  1  serial data to slave; idles 0.
- miso  in  1  serial data from slave.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst). All outputs reset to:
  - busy=0, done=0, res_valid=0, res_addr=0, res_data=0.
  - spi_clk=0, csb=1, ldb=1, mosi=0.
  - All counters 0; FSM to IDLE.
- Reset mid-operation abandons the frame immediately; no done pulse.
- Frame format is 16 bits, MSB first:
  - bit0: R/W (1 = read, 0 = write).
  - bits1-4: address [3:0].
  - bits5-15: data [10:0].
- Bit timing:
  - A half-period counter divides clk by CLK_DIV.
  - Each bit is a high half followed by a low half.
  - mosi changes only on the clk where spi_clk rises; the slave samples on the falling edge.
  - miso is sampled on the clk where spi_clk falls, for bits 5..15 of read frames only, and shifted into res_data LSB-first into a shift register (final value is MSB-first order).
  - During write frames bits 5-15 carry wdata; during read frames they carry 0.
- FSM states:
  - IDLE: on start with busy=0, latch op/addr/wdata and set busy. Scan goes to LOAD; read and write go to SETUP.
  - LOAD: csb=0 and ldb=0 for one half-period, then LDB_CLKS full spi_clk pulses. Then ldb=1, csb=1, go to GAP.
  - SETUP: csb=0 for one half-period before the first rising edge, then SHIFT.
  - SHIFT: 16 spi_clk pulses; bit counter 0..15. After the falling edge of bit15, go to HOLD.
  - HOLD: spi_clk low for one half-period, then csb=1.
    - For read frames: res_valid=1 for one clk with res_addr = frame address.
    - Then go to GAP.
  - GAP: csb high for GAP_CYC clks. Then:
    - Scan with channel counter < 15: increment the counter and go to SETUP.
    - Otherwise: DONE.
  - DONE: done=1 for one clk, busy=0, return to IDLE.
- Scan addresses run 0,1,...,15; the channel counter does not wrap into a second pass.
- A full scan yields exactly 16 res_valid strobes; a single read yields 1; a single write yields 0.
- start while busy=1 is ignored, with no queueing.
- start in the same clk as done is ignored; busy is set the cycle after an accepted start.

Optional Feature:
- Macro: SPI_WRITE_VERIFY_EN.
- Defined:
  - A single write is automatically followed (after GAP) by a read frame to the same address.
  - The read-back data is compared with wdata.
  - Extra output verify_err (1 bit, reset 0) is set on mismatch and cleared at the next accepted start.
  - The read-back also produces res_valid.
- Not defined: no read-back frame, no verify_err port; a single write ends after GAP.

Test Plan:
- Reset with rst asserted mid-SHIFT of a scan -> outputs return to idle values immediately; no done pulse; a new start after release runs a normal scan.
- Scan with sensor_data_k = 11'h100+k at the slave -> ldb low for LDB_CLKS=2 pulses; then 16 res_valid with res_addr 0..15 and res_data 11'h100..11'h10F in order; done once; busy high throughout.
- Single write addr=4'hA, wdata=11'h5A5 -> mosi frame 0_1010_10110100101; csb low for exactly 16 spi_clk pulses; done; no res_valid.
- Single read addr=4'hA after the write -> mosi bits0-4 = 1_1010; res_valid with res_addr=4'hA, res_data=11'h5A5.
- start pulsed while busy and again in the done cycle -> both ignored; busy/done sequence unchanged; spi_clk half-period exactly CLK_DIV clks and csb-high gap exactly GAP_CYC clks.
- With SPI_WRITE_VERIFY_EN, write 11'h3FF with the slave forced to return 11'h3FE -> verify_err=1 after the read-back; the next accepted start clears it.
